uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Each requester offers bytes with a valid/ack handshake. The arbiter picks a winner, latches its byte, and drives the transmitter's `start`/`data_in` pair until the frame is accepted, then waits for the transmitter to become ready again. It sits between the system's message sources (status reporter, debug console, command responder) and the single UART TX pin.

---
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte requesters, uart_tx_arbiter and the UART transmitter.
// slave = arbiter side, master = requesters plus transmitter side.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Handshake: requester i holds req_valid[i]/req_data/req_last until the cycle in
  // which req_ack[i] is high; that cycle is the transfer and the byte may change on
  // the next cycle. tx_start is held until the transmitter has lowered tx_ready.
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 tx_idle;
  logic                 busy;
  logic                 timeout_err;
  logic [1:0]           state_dbg;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready, tx_idle,
    output req_ack, grant, tx_data, tx_start, busy, timeout_err, state_dbg
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready, tx_idle,
    input  req_ack, grant, tx_data, tx_start, busy, timeout_err, state_dbg
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional packet lock (a requester keeps the arbiter until req_last): UART_TX_ARB_PACKET_LOCK_EN.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W:0]   NUM_REQ_W   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q,       state_d;
  logic               rdy_q,         rdy_d;
  logic [PTR_W-1:0]   rr_ptr_q,      rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic [7:0]         tx_data_q,     tx_data_d;
  logic               tx_start_q,    tx_start_d;
  logic [NUM_REQ-1:0] grant_q,       grant_d;
  logic               timeout_err_q, timeout_err_d;
  logic               lock_q,        lock_d;
  logic [NUM_REQ-1:0] lock_mask_q,   lock_mask_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] ack_c;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic               found;
  logic [7:0]         win_data;

  // A held lock narrows the candidates to its owner, which may idle indefinitely.
  assign eligible = (LOCK_EN && lock_q) ? (bus.req_valid & lock_mask_q) : bus.req_valid;

  // First eligible requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign win_data   = bus.req_data[{win_idx, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    rdy_d         = bus.tx_ready;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = tx_start_q;
    grant_d       = grant_q;
    timeout_err_d = 1'b0;
    lock_d        = lock_q;
    lock_mask_d   = lock_mask_q;
    ack_c         = '0;

    unique case (state_q)
      ST_ARB: begin
        if (found) begin
          ack_c       = win_onehot;
          tx_data_d   = win_data;
          grant_d     = win_onehot;
          rr_ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
          cnt_d       = TIMEOUT_VAL;
          tx_start_d  = 1'b1;
          lock_d      = LOCK_EN & ~bus.req_last[win_idx];
          lock_mask_d = win_onehot;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!rdy_q) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT;
        end else if (cnt_q <= CNT_ONE) begin
          // Counter hits zero on this edge: abandon the byte and release any lock.
          tx_start_d    = 1'b0;
          timeout_err_d = 1'b1;
          tx_data_d     = 8'h00;
          grant_d       = '0;
          lock_d        = 1'b0;
          cnt_d         = '0;
          state_d       = ST_ARB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT: begin
        // Ready returns during the stop bit, so the next frame chains without a gap.
        if (rdy_q) begin
          grant_d = '0;
          state_d = ST_ARB;
        end
      end

      default: begin
        state_d    = ST_ARB;
        tx_start_d = 1'b0;
        grant_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ARB;
      rdy_q         <= 1'b0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      grant_q       <= '0;
      timeout_err_q <= 1'b0;
      lock_q        <= 1'b0;
      lock_mask_q   <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      grant_q       <= grant_d;
      timeout_err_q <= timeout_err_d;
      lock_q        <= lock_d;
      lock_mask_q   <= lock_mask_d;
    end
  end

  // req_ack is combinational in ARB, so it is also forced low while reset is held.
  assign bus.req_ack     = ack_c & {NUM_REQ{reset}};
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (|grant_q) | ~bus.tx_idle;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model (ready drops on
// accept, returns during the stop bit) and per-requester byte tables.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int TO      = 50;
  localparam int FRAME   = 10;
  localparam int STOP_AT = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];
  int         rdy_rise_q[$];
  int         start_rise_q[$];
  int         idle_rises = 0;
  int         te_cnt     = 0;
  int         ack_cnt[N];
  logic       stuck = 1'b0;

  logic [8:0] src_mem[N][8];
  int         src_len[N];
  int         src_pos[N];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   l;
    v = '0; d = '0; l = '0;
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        v[i]        = 1'b1;
        d[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
        l[i]        = src_mem[i][src_pos[i]][8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  task automatic load(input int i, input logic [7:0] b, input logic last);
    src_mem[i][src_len[i]] = {last, b};
    src_len[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      ack_cnt[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic done;
    int   n;
    done = 1'b0;
    n    = 0;
    while (!done && n < budget) begin
      sample();
      n++;
      done = (bus.state_dbg == 2'd0) && (bus.grant == '0) && (bus.req_ack == '0) &&
             (bus.tx_idle === 1'b1) && (bus.tx_start === 1'b0);
      for (int i = 0; i < N; i++) begin
        if (src_pos[i] != src_len[i]) done = 1'b0;
      end
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] e;
    logic [7:0] s;
    check({tag, "_len"}, 32'(seen_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = (seen_q.size() > 0) ? seen_q.pop_front() : 8'hxx;
      check(tag, {24'd0, s}, {24'd0, e});
    end
    seen_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    clear_src();
    seen_q.delete();
  endtask

  // ---------------- requester driver ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.req_ack[i] === 1'b1) begin
        ack_cnt[i]++;
        src_pos[i]++;
      end
    end
    @(posedge clk);
    #1;
    drive_reqs();
  end

  // ---------------- transmitter model ----------------
  initial begin
    int mcnt;
    mcnt = 0;
    bus.tx_ready = 1'b1;
    bus.tx_idle  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stuck) begin
        bus.tx_ready = 1'b1;
        bus.tx_idle  = 1'b1;
        mcnt         = 0;
      end else if (bus.tx_start === 1'b1 && bus.tx_ready === 1'b1) begin
        seen_q.push_back(bus.tx_data);
        bus.tx_ready = 1'b0;
        bus.tx_idle  = 1'b0;
        mcnt         = FRAME;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == STOP_AT) begin
          bus.tx_ready = 1'b1;
          rdy_rise_q.push_back(cyc);
        end
        if (mcnt == 0) begin
          bus.tx_idle = 1'b1;
          idle_rises++;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && !prev_start) start_rise_q.push_back(cyc);
      prev_start = (bus.tx_start === 1'b1);
      if (bus.timeout_err === 1'b1) te_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int hi;
    int n;
    int gap;

    clear_src();
    repeat (3) @(posedge clk);
    sample();
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_req_ack", 32'(bus.req_ack), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    #2 reset = 1'b1;

    // Single byte from requester 1
    tick();
    load(1, 8'hA5, 1'b1);
    drive_reqs();
    sample();
    check("single_ack", 32'(bus.req_ack), 32'b0010);
    check("single_start_pre", 32'(bus.tx_start), 32'd0);
    sample();
    check("single_start", 32'(bus.tx_start), 32'd1);
    check("single_data", 32'(bus.tx_data), 32'hA5);
    check("single_grant", 32'(bus.grant), 32'b0010);
    check("single_ack_once", 32'(bus.req_ack), 32'd0);
    check("single_busy", 32'(bus.busy), 32'd1);
    hi = 1;
    n  = 0;
    while (bus.tx_start === 1'b1 && n < 20) begin
      sample();
      n++;
      if (bus.tx_start === 1'b1) hi++;
    end
    check("single_start_cycles", 32'(hi), 32'd2);
    check("single_grant_held", 32'(bus.grant), 32'b0010);
    check("single_ready_low", 32'(bus.tx_ready), 32'd0);
    n = 0;
    while (bus.grant !== '0 && n < 40) begin
      sample();
      n++;
    end
    check("single_grant_release_ready", 32'(bus.tx_ready), 32'd1);
    wait_drain("single_drain", 40);
    exp_q.push_back(8'hA5);
    check_stream("single_byte");
    check("single_ack_cnt", 32'(ack_cnt[1]), 32'd1);

    // Fairness: all four requesters, two bytes each, from rr_ptr 0
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      load(i, 8'h10 + 8'(i), 1'b1);
      load(i, 8'h20 + 8'(i), 1'b1);
    end
    drive_reqs();
    wait_drain("fair_drain", 400);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    check_stream("fair_order");
    for (int i = 0; i < N; i++) check("fair_ack_cnt", 32'(ack_cnt[i]), 32'd2);

    // Packet lock: requester 2 sends a 3-byte packet, requester 0 keeps valid
    do_reset();
    tick();
    load(2, 8'h31, 1'b0);
    load(2, 8'h32, 1'b0);
    load(2, 8'h33, 1'b1);
    drive_reqs();
    tick();
    load(0, 8'h40, 1'b1);
    load(0, 8'h41, 1'b1);
    load(0, 8'h42, 1'b1);
    drive_reqs();
    wait_drain("lock_drain", 400);
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42};
`else
    exp_q = '{8'h31, 8'h40, 8'h32, 8'h41, 8'h33, 8'h42};
`endif
    check_stream("lock_order");

    // Timeout: transmitter never accepts
    tick();
    stuck  = 1'b1;
    te_cnt = 0;
    tick();
    load(1, 8'h77, 1'b1);
    drive_reqs();
    sample();
    check("to_ack", 32'(bus.req_ack), 32'b0010);
    sample();
    hi = 0;
    n  = 0;
    while (bus.tx_start === 1'b1 && n < 200) begin
      hi++;
      sample();
      n++;
    end
    check("to_start_cycles", 32'(hi), 32'd50);
    check("to_err_pulse", 32'(bus.timeout_err), 32'd1);
    check("to_grant_clear", 32'(bus.grant), 32'd0);
    check("to_state_arb", 32'(bus.state_dbg), 32'd0);
    sample();
    check("to_err_one_cycle", 32'(bus.timeout_err), 32'd0);
    check("to_start_low", 32'(bus.tx_start), 32'd0);
    check("to_err_count", 32'(te_cnt), 32'd1);
    check("to_no_frame", 32'(seen_q.size()), 32'd0);
    stuck = 1'b0;

    // Reset during LOAD clears outputs without a clock edge
    stuck = 1'b1;
    tick();
    load(2, 8'h66, 1'b1);
    drive_reqs();
    sample();
    sample();
    check("rmid_in_load", 32'(bus.tx_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rmid_start_clear", 32'(bus.tx_start), 32'd0);
    check("rmid_grant_clear", 32'(bus.grant), 32'd0);
    check("rmid_data_clear", 32'(bus.tx_data), 32'h00);
    check("rmid_state_arb", 32'(bus.state_dbg), 32'd0);
    sample();
    #2 reset = 1'b1;
    stuck = 1'b0;
    clear_src();
    seen_q.delete();
    tick();
    load(3, 8'h83, 1'b1);
    load(0, 8'h80, 1'b1);
    drive_reqs();
    wait_drain("rmid_drain", 200);
    exp_q = '{8'h80, 8'h83};
    check_stream("rmid_order");

    // Back-to-back stream from requester 3
    tick();
    rdy_rise_q.delete();
    start_rise_q.delete();
    idle_rises = 0;
    load(3, 8'h55, 1'b1);
    load(3, 8'hAA, 1'b1);
    drive_reqs();
    wait_drain("b2b_drain", 200);
    exp_q = '{8'h55, 8'hAA};
    check_stream("b2b_order");
    check("b2b_start_count", 32'(start_rise_q.size()), 32'd2);
    gap = 99;
    if (start_rise_q.size() >= 2 && rdy_rise_q.size() >= 1) gap = start_rise_q[1] - rdy_rise_q[0];
    check("b2b_gap_le3", 32'((gap >= 1) && (gap <= 3)), 32'd1);
    check("b2b_no_idle_gap", 32'(idle_rises), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
